c3_issue_queue: RTL and testbench
=================================

# c3_issue_queue

Request buffer and issue pacer sitting directly upstream of the C3 custom-instruction unit (the hardware max-heap with push on rd=0 and pop on rd=1). It absorbs custom-instruction requests from the core into a small FIFO and forwards them one at a time. After each issue it enforces a fixed quiet window so the heap's multi-cycle reorder (heapify), during which it ignores `in_v`, completes before the next request. It also registers the unit's result (pop value) back toward the core.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MIN_GAP`, 6: quiet cycles after each issue; covers worst-case heapify of a 25-entry heap.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_v`  in  1  core request valid; core holds `in_v`/`in_rd`/`in_data` stable until accepted.
- `in_rd`  in  5  opcode/destination field (0 = push, 1 = pop, others forwarded unchanged).
- `in_data`  in  32  operand.
- `in_ready`  out  1  combinational, `count < DEPTH`; accept = `in_v & in_ready`.
- `cu_in_v`  out  1  registered one-cycle issue pulse to C3 unit.
- `cu_rd`  out  5  issued rd; registered, held between issues.
- `cu_in_data`  out  32  issued operand; registered, held.
- `cu_busy`  in  1  C3 unit busy.
- `cu_out_v`, `cu_out_rd[4:0]`, `cu_out_data[31:0]`  in  C3 unit result.
- `out_v`, `out_rd[4:0]`, `out_data[31:0]`  out  result to core, registered copy of `cu_out_*`.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `idle`  out  1  combinational: FIFO empty and FSM in IDLE.

## Operation
- FIFO: write/read pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; entry = {rd, data}, 37 bits. Strict in-order issue; no bypass, no reordering, no filtering of rd values.
- Full: `in_ready`=0; request held by core, nothing lost. Dequeue while full frees a slot in the following cycle, not the same one (no pass-through).
- Simultaneous enqueue + dequeue: `count` unchanged, both pointers advance.
- FSM states:
  - IDLE: if FIFO non-empty, dequeue head, register `cu_in_v`=1 with head's rd/data, load gap counter with MIN_GAP, go to GAP.
  - GAP: decrement counter each cycle; at zero go to WAIT.
  - WAIT: if `cu_busy`=0 go to IDLE; otherwise stay.
- `cu_in_v` high for exactly one cycle per dequeued entry; low in all other cycles.
- Result path: every cycle `out_v` <= `cu_out_v`. When `cu_out_v`=1, `out_rd`/`out_data` <= `cu_out_rd`/`cu_out_data`; otherwise they hold.
- Reset values: `cu_in_v`=0, `cu_rd`=0, `cu_in_data`=0, `out_v`=0, `out_rd`=0, `out_data`=0, `count`=0, pointers 0, state IDLE. Therefore `in_ready`=1 and `idle`=1.
- Reset mid-operation: FIFO contents discarded, any gap or wait aborted. `cu_in_v` is 0 in the cycle after reset is sampled. Requests in flight inside the C3 unit are not tracked.

## Timing
- Request accepted at edge E: `cu_in_v` high in the cycle after edge E+2 when FSM is IDLE and FIFO was empty. Acceptance-to-issue latency is 2 cycles.
- Issue spacing with `cu_busy`=0 and FIFO non-empty: consecutive `cu_in_v` pulses exactly MIN_GAP+2 cycles apart, i.e. 8 with defaults.
- `cu_busy` is sampled only in WAIT. Busy asserted during GAP is ignored; busy held in WAIT delays the next issue until one cycle after busy is seen low.
- Result latency: `cu_out_v` in cycle T produces `out_v` in cycle T+1. Results are independent of FSM state and pass through during GAP, WAIT and reset-free cycles.
- Throughput: at most one issue per MIN_GAP+2 cycles; one accept per cycle until full.

## Test plan
- Reset: assert `reset` 2 cycles with `in_v`=1 → all outputs 0, `in_ready`=1, `count`=0, no `cu_in_v` pulse.
- Single push: accept `in_rd`=0, `in_data`=7 at edge 1 → `cu_in_v`=1, `cu_rd`=0, `cu_in_data`=7 for exactly one cycle after edge 3; `count` back to 0.
- Fill and order: hold `cu_busy`=1 and push data 1..6 → first issues, 4 more fill FIFO, `in_ready`=0 and 6th held. Drop `cu_busy` → remaining issued in order 2,3,4,5,6, each pulse 8 cycles apart.
- Busy hold-off: after an issue, keep `cu_busy`=1 for 20 cycles → next `cu_in_v` exactly one cycle after `cu_busy` is sampled low in WAIT, never during GAP.
- Pop result: `cu_out_v`=1, `cu_out_rd`=1, `cu_out_data`=0x2A at cycle T → `out_v`=1, `out_rd`=1, `out_data`=0x2A at T+1; `out_data` still 0x2A at T+5.
- Reset mid-GAP with 3 entries queued → `count`=0, state IDLE, no further `cu_in_v`. A new push afterwards issues with 2-cycle latency.

Source files
------------

// File: rtl/c3_issue_queue.sv
// c3_issue_queue: request FIFO and issue pacer in front of the C3 heap unit.
// Requests are buffered in order, issued one at a time, and each issue is
// followed by a fixed quiet window (plus a busy wait) so the heap's reorder
// finishes before the next request arrives. Unit results are registered back.
module c3_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_v,
    input  logic [4:0]                 in_rd,
    input  logic [31:0]                in_data,
    output logic                       in_ready,
    output logic                       cu_in_v,
    output logic [4:0]                 cu_rd,
    output logic [31:0]                cu_in_data,
    input  logic                       cu_busy,
    input  logic                       cu_out_v,
    input  logic [4:0]                 cu_out_rd,
    input  logic [31:0]                cu_out_data,
    output logic                       out_v,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       idle
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int GAP_W   = $clog2(MIN_GAP + 1);
    localparam int ENTRY_W = 37;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [1:0]         state;
    logic [GAP_W-1:0]   gap_cnt;
    logic               enq;
    logic               deq;

    logic               vld_p0;
    logic [4:0]         iss_rd_p0;
    logic [31:0]        iss_data_p0;

    // Full is judged on registered occupancy only, so a dequeue while full
    // opens a slot one cycle later rather than passing a request through.
    assign in_ready = (count < FULL_CNT);
    assign enq      = in_v & in_ready;
    assign deq      = (state == S_IDLE) && (count != '0);
    assign idle     = (count == '0) && (state == S_IDLE);

    // FIFO storage write; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wptr] <= {in_rd, in_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pacing FSM: issue from IDLE, count out the quiet window, then wait
    // for the unit to drop busy. The window ends on the edge where the
    // counter reaches zero, giving MIN_GAP+2 cycles between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (deq) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!cu_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- stage p0: head entry captured on dequeue ----
    // Issue staging register holding the dequeued entry
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= deq;
        end
        if (deq) begin
            iss_rd_p0   <= mem[rptr][36:32];
            iss_data_p0 <= mem[rptr][31:0];
        end
    end

    // ---- stage p1: registered issue toward the C3 unit ----
    // One-cycle issue pulse; rd/operand hold their value between issues
    always_ff @(posedge clk) begin
        if (reset) begin
            cu_in_v    <= 1'b0;
            cu_rd      <= '0;
            cu_in_data <= '0;
        end else begin
            cu_in_v <= vld_p0;
            if (vld_p0) begin
                cu_rd      <= iss_rd_p0;
                cu_in_data <= iss_data_p0;
            end
        end
    end

    // Result return path, independent of the pacing FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v    <= 1'b0;
            out_rd   <= '0;
            out_data <= '0;
        end else begin
            out_v <= cu_out_v;
            if (cu_out_v) begin
                out_rd   <= cu_out_rd;
                out_data <= cu_out_data;
            end
        end
    end

endmodule

// File: tb/tb_c3_issue_queue.sv
// Directed testbench for c3_issue_queue with hand-computed expectations.
module tb_c3_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_v;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_ready;
    logic        cu_in_v;
    logic [4:0]  cu_rd;
    logic [31:0] cu_in_data;
    logic        cu_busy;
    logic        cu_out_v;
    logic [4:0]  cu_out_rd;
    logic [31:0] cu_out_data;
    logic        out_v;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        idle;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int          pc[$];
    logic [4:0]  prd[$];
    logic [31:0] pd[$];

    c3_issue_queue #(.DEPTH(4), .MIN_GAP(6)) dut (
        .clk(clk), .reset(reset),
        .in_v(in_v), .in_rd(in_rd), .in_data(in_data), .in_ready(in_ready),
        .cu_in_v(cu_in_v), .cu_rd(cu_rd), .cu_in_data(cu_in_data),
        .cu_busy(cu_busy),
        .cu_out_v(cu_out_v), .cu_out_rd(cu_out_rd), .cu_out_data(cu_out_data),
        .out_v(out_v), .out_rd(out_rd), .out_data(out_data),
        .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    // edge number k sets cyc to k
    always @(posedge clk) cyc <= cyc + 1;

    // record every issue pulse with the edge that produced it
    always @(negedge clk) begin
        if (cu_in_v) begin
            pc.push_back(cyc);
            prd.push_back(cu_rd);
            pd.push_back(cu_in_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic clear_pulses();
        pc.delete();
        prd.delete();
        pd.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && pc.size() < n; i++) step(1);
    endtask

    // present a request and hold it until accepted; e = accepting edge
    task automatic push(input logic [4:0] rd, input logic [31:0] d, output int e);
        bit rdy;
        bit ok;
        ok = 1'b0;
        e = -1;
        in_v = 1'b1;
        in_rd = rd;
        in_data = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = in_ready;
            step(1);
            if (rdy) begin
                ok = 1'b1;
                e = cyc;
            end
        end
        in_v = 1'b0;
        if (!ok) chk("push_accept", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int e, e1, e6, ea, eb, ec, ed, ez, b, t0, r1, r2, r3, r4;
        int ef[1:5];

        reset = 1'b1; in_v = 1'b1; in_rd = 5'd0; in_data = 32'd5;
        cu_busy = 1'b0; cu_out_v = 1'b0; cu_out_rd = 5'd0; cu_out_data = 32'd0;

        // reset held two cycles with a request presented
        step(2);
        chk("rst_cu_in_v", cu_in_v, 0);
        chk("rst_cu_rd", cu_rd, 0);
        chk("rst_cu_in_data", cu_in_data, 0);
        chk("rst_out_v", out_v, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idle", idle, 1);
        in_v = 1'b0;
        reset = 1'b0;
        step(1);
        chk("rst_no_pulse", pc.size(), 0);

        // single push: issue two edges after acceptance
        push(5'd0, 32'd7, e);
        chk("single_count_acc", count, 1);
        step(1);
        chk("single_count_deq", count, 0);
        wait_until(e + 12);
        chk("single_npulse", pc.size(), 1);
        if (pc.size() >= 1) begin
            chk("single_time", pc[0], e + 2);
            chk("single_rd", prd[0], 0);
            chk("single_data", pd[0], 7);
        end
        chk("single_idle", idle, 1);
        clear_pulses();

        // fill with busy high, sixth request held, then drain in order
        cu_busy = 1'b1;
        for (int i = 1; i <= 5; i++) push(5'(i * 6), 32'(i), ef[i]);
        e1 = ef[1];
        chk("fill_b2b", ef[5], e1 + 4);
        in_v = 1'b1; in_rd = 5'd31; in_data = 32'd6;
        step(3);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_count", count, 4);
        chk("fill_first_n", pc.size(), 1);
        if (pc.size() >= 1) begin
            chk("fill_first_time", pc[0], e1 + 2);
            chk("fill_first_data", pd[0], 1);
        end
        wait_until(e1 + 15);
        chk("fill_held_n", pc.size(), 1);
        cu_busy = 1'b0;
        b = cyc;
        push(5'd31, 32'd6, e6);
        wait_pulses(6, 100);
        chk("fill_npulse", pc.size(), 6);
        if (pc.size() >= 6) begin
            chk("fill_release_time", pc[1], b + 3);
            for (int k = 1; k < 6; k++) begin
                chk("fill_order", pd[k], k + 1);
                chk("fill_spacing", pc[k] - pc[k-1], (k == 1) ? pc[1] - pc[0] : 8);
            end
            chk("fill_rd2", prd[1], 12);
            chk("fill_rd6", prd[5], 31);
        end
        step(12);
        clear_pulses();

        // busy during the quiet window is ignored: spacing stays 8
        push(5'd2, 32'h11, ea);
        push(5'd3, 32'h22, eb);
        wait_until(ea + 2);
        cu_busy = 1'b1;
        wait_until(ea + 6);
        cu_busy = 1'b0;
        wait_pulses(2, 40);
        chk("gapbusy_npulse", pc.size(), 2);
        if (pc.size() >= 2) begin
            chk("gapbusy_t0", pc[0], ea + 2);
            chk("gapbusy_t1", pc[1], ea + 10);
            chk("gapbusy_d1", pd[1], 32'h22);
        end
        step(12);
        clear_pulses();

        // busy held 20 cycles in WAIT delays the next issue
        push(5'd4, 32'h33, ec);
        cu_busy = 1'b1;
        push(5'd5, 32'h44, ed);
        wait_until(ec + 20);
        chk("holdoff_n_before", pc.size(), 1);
        cu_busy = 1'b0;
        b = cyc;
        wait_pulses(2, 40);
        chk("holdoff_npulse", pc.size(), 2);
        if (pc.size() >= 2) begin
            chk("holdoff_t0", pc[0], ec + 2);
            chk("holdoff_t1", pc[1], b + 3);
            chk("holdoff_rd1", prd[1], 5);
        end
        step(12);
        clear_pulses();

        // result path: registered one cycle later, held afterwards
        t0 = cyc;
        cu_out_v = 1'b1; cu_out_rd = 5'd1; cu_out_data = 32'h2A;
        step(1);
        cu_out_v = 1'b0; cu_out_rd = 5'd3; cu_out_data = 32'h55;
        chk("res_out_v", out_v, 1);
        chk("res_out_rd", out_rd, 1);
        chk("res_out_data", out_data, 32'h2A);
        step(1);
        chk("res_out_v_drop", out_v, 0);
        chk("res_hold_data1", out_data, 32'h2A);
        wait_until(t0 + 5);
        chk("res_hold_data5", out_data, 32'h2A);
        chk("res_hold_rd5", out_rd, 1);
        cu_out_v = 1'b1; cu_out_rd = 5'd2; cu_out_data = 32'hDEADBEEF;
        step(1);
        cu_out_v = 1'b0;
        chk("res2_out_data", out_data, 32'hDEADBEEF);
        chk("res2_out_rd", out_rd, 2);

        // reset during the quiet window with three entries queued
        push(5'd1, 32'hA1, r1);
        push(5'd2, 32'hA2, r2);
        push(5'd3, 32'hA3, r3);
        push(5'd4, 32'hA4, r4);
        chk("midrst_count_before", count, 3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_cu_in_v", cu_in_v, 0);
        chk("midrst_cu_in_data", cu_in_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        step(20);
        chk("midrst_npulse", pc.size(), 1);
        push(5'd0, 32'hBEEF, ez);
        wait_until(ez + 4);
        chk("midrst_new_npulse", pc.size(), 2);
        if (pc.size() >= 2) begin
            chk("midrst_new_time", pc[1], ez + 2);
            chk("midrst_new_data", pd[1], 32'hBEEF);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
